// File: rtl/spi_pkg.sv
// Shared SPI master types and default sizing.
package spi_pkg;

  localparam int unsigned WORD_BITS_DEF   = 24;
  localparam int unsigned HALF_PERIOD_DEF = 4;
  localparam int unsigned HP_CNT_W        = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_HIGH,
    SCK_LOW,
    TAIL,
    HOLD,
    GAP
  } state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period down-counter; strobes on the last cycle of each phase and
// restarts whenever the FSM changes state.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = HALF_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  output logic phase_end_c
);

  localparam logic [HP_CNT_W-1:0] LOAD = HP_CNT_W'(HALF_PERIOD - 1);

  logic [HP_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= LOAD;
    end else if (reload || (cnt == '0)) begin
      cnt <= LOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign phase_end_c = (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: MSB-first words, optional ssel hold between words,
// all pad-facing outputs registered.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = HALF_PERIOD_DEF,
  parameter int unsigned WORD_BITS   = WORD_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 hold,
  input  logic [WORD_BITS-1:0] dataToSend,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_BITS-1:0] receivedData,
  output logic                 sck,
  output logic                 mosi,
  input  logic                 miso,
  output logic                 ssel
);

  localparam int unsigned BIT_W = $clog2(WORD_BITS + 1);

  state_t               state;
  state_t               state_next;
  logic                 phase_end_c;
  logic                 reload_c;
  logic                 accept_c;
  logic                 shift_c;
  logic                 word_end_c;
  logic [BIT_W-1:0]     bit_cnt;
  logic [WORD_BITS-1:0] tx_shift;
  logic [WORD_BITS-1:0] rx_shift;

  assign reload_c = (state_next != state);

  spi_clk_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_clk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .reload     (reload_c),
    .phase_end_c(phase_end_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Every bit gets a full high and low phase, so the last low phase leads to TAIL.
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    shift_c    = 1'b0;
    word_end_c = 1'b0;
    case (state)
      IDLE, HOLD: begin
        if (start) begin
          accept_c   = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP:    if (phase_end_c) state_next = SCK_HIGH;
      SCK_HIGH: begin
        if (phase_end_c) begin
          shift_c    = 1'b1;
          state_next = SCK_LOW;
        end
      end
      SCK_LOW: begin
        if (phase_end_c) begin
          state_next = (bit_cnt == BIT_W'(WORD_BITS)) ? TAIL : SCK_HIGH;
        end
      end
      TAIL: begin
        if (phase_end_c) begin
          word_end_c = 1'b1;
          state_next = hold ? HOLD : GAP;
        end
      end
      GAP:      if (phase_end_c) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Pin outputs decode the next state so they toggle on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck          <= 1'b0;
      ssel         <= 1'b1;
      mosi         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      receivedData <= '0;
      bit_cnt      <= '0;
      tx_shift     <= '0;
      rx_shift     <= '0;
    end else begin
      sck  <= (state_next == SCK_HIGH);
      ssel <= (state_next inside {IDLE, GAP});
      busy <= !(state_next inside {IDLE, HOLD});
      done <= word_end_c;
      if (accept_c) begin
        tx_shift <= dataToSend;
        mosi     <= dataToSend[WORD_BITS-1];
        bit_cnt  <= '0;
      end else if (shift_c) begin
        tx_shift <= tx_shift << 1;
        mosi     <= tx_shift[WORD_BITS-2];
        rx_shift <= {rx_shift[WORD_BITS-2:0], miso};
        bit_cnt  <= bit_cnt + 1'b1;
      end
      if (word_end_c) begin
        receivedData <= rx_shift;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Randomized scoreboard bench for spi_master with a behavioural SPI slave.
module tb_spi_master;

  localparam int unsigned HP  = 4;
  localparam int unsigned WB  = 24;
  localparam int          LAT = HP * (2 * WB + 2) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic          loop_en = 1'b0;
  logic [WB-1:0] dataToSend = '0;
  logic [WB-1:0] slave_word = '0;
  logic [WB-1:0] receivedData;
  logic          busy, done, sck, mosi, miso, ssel;

  int vec = 0;
  int errs = 0;
  int cyc = 0;
  int done_cnt = 0;

  typedef struct {
    logic [WB-1:0] rx;
    logic [WB-1:0] tx;
    int            acc;
  } exp_t;
  exp_t exp_q[$];

  // Behavioural slave: samples mosi after sck rises, shifts miso after sck falls.
  int            slave_pos = 0;
  int            slave_rises = 0;
  logic          slave_psck = 1'b0;
  logic [WB-1:0] slave_sh = '0;
  logic [WB-1:0] slave_cap = '0;

  assign miso = loop_en ? mosi : slave_word[WB-1-slave_pos];

  spi_master #(
    .HALF_PERIOD(HP),
    .WORD_BITS  (WB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .hold        (hold),
    .dataToSend  (dataToSend),
    .busy        (busy),
    .done        (done),
    .receivedData(receivedData),
    .sck         (sck),
    .mosi        (mosi),
    .miso        (miso),
    .ssel        (ssel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ssel) begin
      slave_pos   <= 0;
      slave_rises <= 0;
    end else if (sck && !slave_psck) begin
      slave_sh    <= {slave_sh[WB-2:0], mosi};
      slave_rises <= slave_rises + 1;
    end else if (!sck && slave_psck) begin
      if (slave_rises == WB) begin
        slave_cap   <= slave_sh;
        slave_rises <= 0;
        slave_pos   <= 0;
      end else begin
        slave_pos <= slave_rises;
      end
    end
    slave_psck <= sck;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vec++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pin-level rules every cycle, scoreboard pop on each done pulse.
  initial begin
    logic psck;
    logic pmosi;
    int   rises;
    exp_t e;
    psck  = 1'b0;
    pmosi = 1'b0;
    rises = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rises = 0;
      end else begin
        if (sck && !psck) rises++;
        if (ssel) chk("sck_low_while_deselected", 32'(sck), 0);
        if (sck && psck) chk("mosi_stable_sck_high", 32'(mosi), 32'(pmosi));
        if (done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("receivedData", 32'(receivedData), 32'(e.rx));
            chk("done_latency", 32'(cyc - e.acc), 32'(LAT));
            chk("sck_rising_edges", 32'(rises), 32'(WB));
            chk("slave_received", 32'(slave_cap), 32'(e.tx));
          end
          rises = 0;
        end
      end
      psck  = sck;
      pmosi = mosi;
    end
  end

  task automatic send(input logic [WB-1:0] d, input logic [WB-1:0] sw, input logic lp,
                      input logic h, input bit inject, input bit wait_done);
    exp_t e;
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
    chk("idle_before_start", 32'(busy), 0);
    dataToSend = d;
    slave_word = sw;
    loop_en    = lp;
    hold       = h;
    start      = 1'b1;
    e.rx       = lp ? d : sw;
    e.tx       = d;
    e.acc      = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    start      = 1'b0;
    dataToSend = WB'($urandom);
    chk("busy_after_accept", 32'(busy), 1);
    chk("ssel_after_accept", 32'(ssel), 0);
    if (inject) begin
      repeat (48) @(negedge clk);
      start      = 1'b1;
      dataToSend = ~d;
      @(negedge clk);
      start = 1'b0;
    end
    if (wait_done) begin
      for (int i = 0; i < 2000 && !done; i++) @(negedge clk);
      chk("done_seen", 32'(done), 1);
    end
  endtask

  initial begin
    int hi;
    int d0;

    repeat (3) @(negedge clk);
    chk("reset_ssel", 32'(ssel), 1);
    chk("reset_sck", 32'(sck), 0);
    chk("reset_mosi", 32'(mosi), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_receivedData", 32'(receivedData), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send(24'hA5F00F, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b1);
    send(24'h123456, WB'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);

    for (int n = 0; n < 6; n++) begin
      send(WB'($urandom), WB'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end

    // Two words back to back through HOLD; ssel must never rise in between.
    send(WB'($urandom), WB'($urandom), 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("ssel_low_in_hold", 32'(ssel), 0);
    chk("busy_low_in_hold", 32'(busy), 0);
    send(WB'($urandom), WB'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    hi = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (ssel) hi++;
      @(negedge clk);
    end
    chk("done_seen_second_word", 32'(done), 1);
    chk("ssel_high_cycles_in_chain", 32'(hi), 0);

    send(WB'($urandom), WB'($urandom), 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (HP * 3) @(negedge clk);

    // Abort during bit 10.
    send(WB'($urandom), WB'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (HP * 19) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    chk("abort_ssel", 32'(ssel), 1);
    chk("abort_sck", 32'(sck), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    rst_n = 1'b1;
    repeat (HP * 4) @(negedge clk);
    chk("no_done_after_abort", 32'(done_cnt - d0), 0);
    send(WB'($urandom), WB'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
    send(WB'($urandom), 24'h000000, 1'b1, 1'b0, 1'b0, 1'b1);

    repeat (HP * 4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
